// File: rtl/game_sequencer.sv
// game_sequencer: turns frame strobes into physics update requests and runs the game life cycle
module game_sequencer #(
    parameter int LIVES_INIT         = 3,
    parameter int LOST_DELAY_FRAMES  = 60,
    parameter int CLEAR_DELAY_FRAMES = 120
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        FRAME_RENDERED,
    input  logic        SW_PAUSE,
    input  logic        BTN_RELEASE,
    input  logic        UPDATE_DONE,
    input  logic        BALL_LOST,
    input  logic [71:0] BLOCK_STATE,
    output logic        START_UPDATE,
    output logic        BALL_RESET,
    output logic        PHYSICS_RESET,
    output logic        BALL_RELEASE,
    output logic [2:0]  GAME_STATE,
    output logic [1:0]  LIVES,
    output logic [3:0]  LEVEL,
    output logic        PAUSED,
    output logic [7:0]  OVERRUN
);
    typedef enum logic [2:0] {
        ATTRACT = 3'd0,
        SERVE   = 3'd1,
        PLAY    = 3'd2,
        LOST    = 3'd3,
        CLEAR   = 3'd4,
        OVER    = 3'd5
    } state_t;

    state_t     state, nxt;
    logic       busy, rel_prev;
    logic [7:0] delay, delay_d;
    logic [1:0] lives_d;
    logic [3:0] level_d;
    logic       ball_reset_d, physics_reset_d, ball_release_d;
    logic       rel_ok, frame_ok, active, issue, drop, timed_out;

    // Pause gates release edges and frames; the edge history keeps updating so a press made while paused is lost
    assign rel_ok    = BTN_RELEASE & ~rel_prev & ~PAUSED;
    assign frame_ok  = FRAME_RENDERED & ~PAUSED;
    assign active    = (state == SERVE) || (state == PLAY);
    assign issue     = active & frame_ok & ~busy;
    assign drop      = active & frame_ok & busy;
    assign timed_out = (delay == 8'd0) && !busy;
    assign GAME_STATE = state;

    // State register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= ATTRACT;
        else        state <= nxt;
    end

    // Next-state decision for the game life cycle; a cleared field outranks a lost ball
    always_comb begin
        nxt = state;
        case (state)
            ATTRACT:     if (rel_ok) nxt = SERVE;
            SERVE:       if (rel_ok) nxt = PLAY;
            PLAY: begin
                if (UPDATE_DONE && BLOCK_STATE == '0) nxt = CLEAR;
                else if (BALL_LOST)                   nxt = (LIVES == 2'd1) ? OVER : LOST;
            end
            LOST, CLEAR: if (timed_out) nxt = SERVE;
            OVER:        if (rel_ok) nxt = ATTRACT;
            default:     nxt = ATTRACT;
        endcase
    end

    // Next values of the registered outputs: pulses, lives, level and delay counter
    always_comb begin
        lives_d         = LIVES;
        level_d         = LEVEL;
        delay_d         = delay;
        ball_reset_d    = 1'b0;
        physics_reset_d = 1'b0;
        ball_release_d  = 1'b0;
        if ((state == LOST || state == CLEAR) && frame_ok && delay != 8'd0) delay_d = delay - 8'd1;
        case (state)
            ATTRACT: if (rel_ok) begin
                lives_d         = LIVES_INIT[1:0];
                level_d         = 4'd0;
                physics_reset_d = 1'b1;
            end
            SERVE: ball_release_d = rel_ok;
            PLAY: begin
                if (nxt == CLEAR) delay_d = CLEAR_DELAY_FRAMES[7:0];
                else if (BALL_LOST) begin
                    lives_d = LIVES - 2'd1;
                    delay_d = LOST_DELAY_FRAMES[7:0];
                end
            end
            LOST: ball_reset_d = timed_out;
            CLEAR: if (timed_out) begin
                physics_reset_d = 1'b1;
                level_d         = (LEVEL == 4'd15) ? LEVEL : LEVEL + 4'd1;
            end
            default: ;
        endcase
    end

    // Output and datapath registers; busy set outranks a same-cycle UPDATE_DONE
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            PAUSED        <= 1'b0;
            rel_prev      <= 1'b1;
            busy          <= 1'b0;
            delay         <= 8'd0;
            START_UPDATE  <= 1'b0;
            BALL_RESET    <= 1'b0;
            PHYSICS_RESET <= 1'b0;
            BALL_RELEASE  <= 1'b0;
            LIVES         <= 2'd0;
            LEVEL         <= 4'd0;
            OVERRUN       <= 8'd0;
        end else begin
            PAUSED        <= SW_PAUSE;
            rel_prev      <= BTN_RELEASE;
            busy          <= issue | (busy & ~UPDATE_DONE);
            delay         <= delay_d;
            START_UPDATE  <= issue;
            BALL_RESET    <= ball_reset_d;
            PHYSICS_RESET <= physics_reset_d;
            BALL_RELEASE  <= ball_release_d;
            LIVES         <= lives_d;
            LEVEL         <= level_d;
            if (drop && OVERRUN != 8'hff) OVERRUN <= OVERRUN + 8'd1;
        end
    end
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed and randomized checks of game_sequencer against a rule-level model
module tb_game_sequencer;
    localparam int LIVES_INIT = 3;
    localparam int LOST_D     = 60;
    localparam int CLEAR_D    = 120;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        FRAME_RENDERED = 1'b0, SW_PAUSE = 1'b0, BTN_RELEASE = 1'b0;
    logic        UPDATE_DONE = 1'b0, BALL_LOST = 1'b0;
    logic [71:0] BLOCK_STATE = '1;
    logic        START_UPDATE, BALL_RESET, PHYSICS_RESET, BALL_RELEASE, PAUSED;
    logic [2:0]  GAME_STATE;
    logic [1:0]  LIVES;
    logic [3:0]  LEVEL;
    logic [7:0]  OVERRUN;

    int n_vec = 0, n_err = 0;
    int cnt;

    // Model state held as plain numbers
    int m_st, m_lives, m_level, m_paused, m_ovr, m_busy, m_delay, m_prev;
    int m_su, m_bres, m_pres, m_brel;

    game_sequencer #(.LIVES_INIT(LIVES_INIT), .LOST_DELAY_FRAMES(LOST_D), .CLEAR_DELAY_FRAMES(CLEAR_D)) dut (
        .CLK(CLK), .RESET(RESET), .FRAME_RENDERED(FRAME_RENDERED), .SW_PAUSE(SW_PAUSE),
        .BTN_RELEASE(BTN_RELEASE), .UPDATE_DONE(UPDATE_DONE), .BALL_LOST(BALL_LOST),
        .BLOCK_STATE(BLOCK_STATE), .START_UPDATE(START_UPDATE), .BALL_RESET(BALL_RESET),
        .PHYSICS_RESET(PHYSICS_RESET), .BALL_RELEASE(BALL_RELEASE), .GAME_STATE(GAME_STATE),
        .LIVES(LIVES), .LEVEL(LEVEL), .PAUSED(PAUSED), .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    function automatic void m_reset();
        m_st = 0; m_lives = 0; m_level = 0; m_paused = 0; m_ovr = 0;
        m_busy = 0; m_delay = 0; m_prev = 1;
        m_su = 0; m_bres = 0; m_pres = 0; m_brel = 0;
    endfunction

    // One clock of game rules applied to the inputs currently driven
    function automatic void m_step();
        bit rel, fok, act, tout;
        rel  = BTN_RELEASE && !m_prev && !m_paused;
        fok  = FRAME_RENDERED && !m_paused;
        act  = (m_st == 1 || m_st == 2);
        tout = (m_delay == 0) && !m_busy;
        m_bres = 0; m_pres = 0; m_brel = 0;
        m_su = act && fok && !m_busy;
        if (act && fok && m_busy && m_ovr < 255) m_ovr++;
        if ((m_st == 3 || m_st == 4) && fok && m_delay > 0) m_delay--;
        if (m_st == 0 && rel) begin
            m_st = 1; m_lives = LIVES_INIT; m_level = 0; m_pres = 1;
        end else if (m_st == 1 && rel) begin
            m_st = 2; m_brel = 1;
        end else if (m_st == 2 && UPDATE_DONE && BLOCK_STATE == 0) begin
            m_st = 4; m_delay = CLEAR_D;
        end else if (m_st == 2 && BALL_LOST) begin
            m_lives--; m_st = (m_lives == 0) ? 5 : 3; m_delay = LOST_D;
        end else if (m_st == 3 && tout) begin
            m_st = 1; m_bres = 1;
        end else if (m_st == 4 && tout) begin
            m_st = 1; m_pres = 1; m_level = (m_level < 15) ? m_level + 1 : 15;
        end else if (m_st == 5 && rel) begin
            m_st = 0;
        end
        m_busy   = m_su || (m_busy && !UPDATE_DONE);
        m_paused = SW_PAUSE;
        m_prev   = BTN_RELEASE;
    endfunction

    function automatic logic [31:0] model_vec();
        return {10'd0, m_su[0], m_bres[0], m_pres[0], m_brel[0], m_st[2:0], m_lives[1:0],
                m_level[3:0], m_paused[0], m_ovr[7:0]};
    endfunction

    function automatic logic [31:0] dut_vec();
        return {10'd0, START_UPDATE, BALL_RESET, PHYSICS_RESET, BALL_RELEASE, GAME_STATE, LIVES,
                LEVEL, PAUSED, OVERRUN};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, compare every output with the model, then drop the one-cycle strobes
    task automatic tick();
        if (!RESET) m_reset();
        else m_step();
        @(posedge CLK);
        #1;
        chk("cycle", dut_vec(), model_vec());
        FRAME_RENDERED = 1'b0;
        UPDATE_DONE    = 1'b0;
        BALL_LOST      = 1'b0;
    endtask

    task automatic press();
        BTN_RELEASE = 1'b1; tick();
        BTN_RELEASE = 1'b0; tick();
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            FRAME_RENDERED = 1'b1; tick();
            tick();
        end
    endtask

    initial begin
        m_reset();
        @(posedge CLK); #1;
        chk("rst_vec", dut_vec(), model_vec());
        repeat (2) tick();
        chk("rst_state", {29'd0, GAME_STATE}, 32'd0);
        RESET = 1'b1;
        tick();

        // Start a game
        BTN_RELEASE = 1'b1; tick();
        chk("start_pres", {31'd0, PHYSICS_RESET}, 32'd1);
        chk("start_state", {29'd0, GAME_STATE}, 32'd1);
        chk("start_lives", {30'd0, LIVES}, 32'd3);
        BTN_RELEASE = 1'b0; tick();
        chk("start_pres_once", {31'd0, PHYSICS_RESET}, 32'd0);
        FRAME_RENDERED = 1'b1; tick();
        chk("su_latency", {31'd0, START_UPDATE}, 32'd1);
        UPDATE_DONE = 1'b1; tick();

        // Serve, then overrun while physics stays busy
        BTN_RELEASE = 1'b1; tick();
        chk("serve_brel", {31'd0, BALL_RELEASE}, 32'd1);
        chk("serve_state", {29'd0, GAME_STATE}, 32'd2);
        BTN_RELEASE = 1'b0; tick();
        cnt = 0;
        repeat (3) begin
            FRAME_RENDERED = 1'b1; tick(); cnt += int'(START_UPDATE);
            tick(); cnt += int'(START_UPDATE);
        end
        chk("su_count", cnt, 32'd1);
        chk("overrun", {24'd0, OVERRUN}, 32'd2);
        UPDATE_DONE = 1'b1; tick();

        // Lose all three balls
        for (int k = 0; k < 3; k++) begin
            BALL_LOST = 1'b1; tick();
            chk("lost_lives", {30'd0, LIVES}, 2 - k);
            chk("lost_state", {29'd0, GAME_STATE}, (k == 2) ? 5 : 3);
            if (k < 2) begin
                cnt = 0;
                repeat (LOST_D) begin
                    FRAME_RENDERED = 1'b1; tick(); cnt += int'(BALL_RESET);
                    tick(); cnt += int'(BALL_RESET);
                end
                repeat (2) begin tick(); cnt += int'(BALL_RESET); end
                chk("ball_reset_once", cnt, 32'd1);
                chk("reserve_state", {29'd0, GAME_STATE}, 32'd1);
                press();
            end
        end
        press();
        chk("over_to_attract", {29'd0, GAME_STATE}, 32'd0);
        chk("over_lives", {30'd0, LIVES}, 32'd0);

        // Clear beats a simultaneous ball loss
        press();
        press();
        UPDATE_DONE = 1'b1; BALL_LOST = 1'b1; BLOCK_STATE = '0; tick();
        BLOCK_STATE = '1;
        chk("clear_state", {29'd0, GAME_STATE}, 32'd4);
        chk("clear_lives", {30'd0, LIVES}, 32'd3);
        cnt = 0;
        repeat (CLEAR_D) begin
            FRAME_RENDERED = 1'b1; tick(); cnt += int'(PHYSICS_RESET);
            tick(); cnt += int'(PHYSICS_RESET);
        end
        repeat (2) begin tick(); cnt += int'(PHYSICS_RESET); end
        chk("clear_pres", cnt, 32'd1);
        chk("clear_level", {28'd0, LEVEL}, 32'd1);
        chk("clear_serve", {29'd0, GAME_STATE}, 32'd1);

        // Release edge during pause is dropped, not queued
        SW_PAUSE = 1'b1; tick();
        BTN_RELEASE = 1'b1; tick();
        chk("pause_rel", {29'd0, GAME_STATE}, 32'd1);
        SW_PAUSE = 1'b0; repeat (2) tick();
        chk("pause_noqueue", {29'd0, GAME_STATE}, 32'd1);
        BTN_RELEASE = 1'b0; tick();
        press();

        // Paused in PLAY: frames ignored
        SW_PAUSE = 1'b1; tick();
        cnt = 0;
        repeat (4) begin
            FRAME_RENDERED = 1'b1; tick(); cnt += int'(START_UPDATE);
        end
        chk("pause_no_su", cnt, 32'd0);
        SW_PAUSE = 1'b0; tick();

        // Paused in LOST: delay counter frozen then resumes
        BALL_LOST = 1'b1; tick();
        frames(30);
        SW_PAUSE = 1'b1; tick();
        frames(100);
        chk("pause_frozen", {29'd0, GAME_STATE}, 32'd3);
        SW_PAUSE = 1'b0; tick();
        frames(29);
        chk("resume_count", {29'd0, GAME_STATE}, 32'd3);
        frames(1);
        chk("resume_exit", {29'd0, GAME_STATE}, 32'd1);

        // Reset while busy with the button held
        press();
        FRAME_RENDERED = 1'b1; tick();
        BTN_RELEASE = 1'b1;
        RESET = 1'b0;
        m_reset();
        #1;
        chk("async_rst", {29'd0, GAME_STATE}, 32'd0);
        repeat (2) tick();
        RESET = 1'b1;
        UPDATE_DONE = 1'b1; tick();
        repeat (4) tick();
        chk("held_btn", {29'd0, GAME_STATE}, 32'd0);
        BTN_RELEASE = 1'b0; tick();
        press();
        chk("rst_restart", {29'd0, GAME_STATE}, 32'd1);
        FRAME_RENDERED = 1'b1; tick();
        chk("rst_busy_clear", {31'd0, START_UPDATE}, 32'd1);

        // Randomized play
        for (int i = 0; i < 6000; i++) begin
            RESET          = ($urandom_range(0, 2999) != 0);
            FRAME_RENDERED = ($urandom_range(0, 2) == 0);
            UPDATE_DONE    = ($urandom_range(0, 3) == 0);
            BALL_LOST      = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 59) == 0) SW_PAUSE = ~SW_PAUSE;
            if ($urandom_range(0, 7) == 0) BTN_RELEASE = ~BTN_RELEASE;
            BLOCK_STATE = ($urandom_range(0, 3) == 0) ? 72'd0 : {$urandom, $urandom, $urandom} | 72'd1;
            if (!RESET) begin
                m_reset();
                #1;
                chk("rand_async_rst", dut_vec(), model_vec());
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level game-flow controller between the frame renderer and the physics engine. It turns per-frame `FRAME_RENDERED` strobes into handshaked physics update requests and owns the game life cycle: attract, serve, play, ball lost, level clear and game over. It tracks lives and level, and issues ball and field reset pulses to the physics engine. Pause is handled here, so the physics engine never sees a request while paused.

## Interface
Parameters:
- `LIVES_INIT`, 3: lives at game start (1..3).
- `LOST_DELAY_FRAMES`, 60: frames spent in LOST before re-serve (1..255).
- `CLEAR_DELAY_FRAMES`, 120: frames spent in CLEAR before next level (1..255).

Ports:
- `CLK`  in  1  system clock; all logic on rising edge.
- `RESET`  in  1  asynchronous, active-low reset.
- `FRAME_RENDERED`  in  1  one-cycle strobe at end of each frame.
- `SW_PAUSE`  in  1  level; 1 = paused.
- `BTN_RELEASE`  in  1  level; synchronised and debounced upstream.
- `UPDATE_DONE`  in  1  one-cycle strobe from physics; ends an update.
- `BALL_LOST`  in  1  one-cycle strobe from physics; ball passed the paddle.
- `BLOCK_STATE`  in  72  live-block bitmap from physics.
- `START_UPDATE`  out  1  one-cycle request for one physics step.
- `BALL_RESET`  out  1  one-cycle pulse; re-attach ball to paddle, blocks kept.
- `PHYSICS_RESET`  out  1  one-cycle pulse; full field reload: blocks, ball, paddle.
- `BALL_RELEASE`  out  1  one-cycle pulse; launch the ball.
- `GAME_STATE`  out  3  state code: 0 ATTRACT, 1 SERVE, 2 PLAY, 3 LOST, 4 CLEAR, 5 OVER.
- `LIVES`  out  2  remaining lives.
- `LEVEL`  out  4  current level; saturates at 15.
- `PAUSED`  out  1  registered copy of `SW_PAUSE`.
- `OVERRUN`  out  8  saturating count of frames dropped because physics was busy.

## Operation
- Busy flag:
  - set when `START_UPDATE` is issued;
  - cleared on `UPDATE_DONE`;
  - if both happen in the same cycle, set wins.
- Update issue: in SERVE or PLAY, a `FRAME_RENDERED` with `PAUSED`=0 issues `START_UPDATE`.
  - If busy, no request is issued; `OVERRUN` increments (saturates at 255).
  - In every other state, or when paused, frames are ignored and do not count as overruns.
- Release edge: internal rising-edge detect on `BTN_RELEASE`. A held button produces exactly one event.
- ATTRACT:
  - On release edge: `LIVES`←`LIVES_INIT`, `LEVEL`←0, pulse `PHYSICS_RESET`, go to SERVE.
- SERVE:
  - On release edge with not paused: pulse `BALL_RELEASE`, go to PLAY.
- PLAY:
  - On `UPDATE_DONE`, if `BLOCK_STATE`==0: go to CLEAR; delay counter ← `CLEAR_DELAY_FRAMES`.
  - Else on `BALL_LOST`: `LIVES`−1. If the result is 0, go to OVER; otherwise go to LOST with delay counter ← `LOST_DELAY_FRAMES`.
  - If both occur in the same cycle, CLEAR wins and no life is lost.
- LOST and CLEAR:
  - Delay counter decrements on each unpaused `FRAME_RENDERED`.
  - When it reaches 0: wait until busy=0, then leave.
  - LOST goes to SERVE with a `BALL_RESET` pulse.
  - CLEAR goes to SERVE with a `PHYSICS_RESET` pulse and `LEVEL`+1 (saturating at 15).
- OVER: on release edge, go to ATTRACT. `LIVES` stays 0.
- `BALL_LOST` and `BLOCK_STATE` are ignored outside PLAY.
- `SW_PAUSE` also freezes delay counters and blocks release edges. A release edge that occurs while paused is discarded, not queued.

## Timing
- All outputs are registered. Every pulse output is high for exactly one cycle.
- `START_UPDATE` is high in cycle N+1 when `FRAME_RENDERED` is high in cycle N.
- State change and the associated pulse appear together, one cycle after the triggering input. `GAME_STATE` updates in that same cycle.
- `PAUSED` lags `SW_PAUSE` by one cycle. Gating decisions use `PAUSED`.
- Reset, asynchronous, `RESET`=0:
  - `GAME_STATE`=ATTRACT, `LIVES`=0, `LEVEL`=0, `OVERRUN`=0;
  - all pulses 0, busy=0, delay counter=0, release-edge history=1 (a button held through reset does not start a game).
- Reset in the middle of an update discards the busy flag. A late `UPDATE_DONE` arriving after reset has no effect.

## Test plan
- Reset, then release edge → `PHYSICS_RESET` pulse, `GAME_STATE`=1, `LIVES`=3; a further frame → `START_UPDATE` exactly 1 cycle after `FRAME_RENDERED`.
- SERVE with release edge → `BALL_RELEASE`, state 2. Then 3 `FRAME_RENDERED` strobes with no `UPDATE_DONE` → 1 `START_UPDATE`, `OVERRUN`=2.
- In PLAY, `BALL_LOST` three times, each followed by 60 frames and a re-serve → `LIVES` 2, 1, then state 5. Each LOST→SERVE exit emits `BALL_RESET`.
- `UPDATE_DONE` with `BLOCK_STATE`=0 in the same cycle as `BALL_LOST` → state 4 with `LIVES` unchanged. After 120 frames → `PHYSICS_RESET`, `LEVEL`=1, state 1.
- `SW_PAUSE`=1 in PLAY and in LOST → no `START_UPDATE`, delay counter frozen, release edge ignored. Unpause → counting resumes from the frozen value.
- `RESET` asserted while busy, with `BTN_RELEASE` held → state 0, no game start until the button is released and pressed again.
